adc_chirp_framer: RTL and testbench

//  Source side of the range-window chirp stream: turns the free-running raw ADC I/Q sample stream into

---
 rtl/adc_chirp_framer_if.sv | 22 ++
 rtl/adc_chirp_framer.sv | 148 ++++++++++++++
 tb/tb_adc_chirp_framer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_chirp_framer_if.sv
// rtl/adc_chirp_framer_if.sv - raw ADC input stream and framed chirp output stream
interface adc_chirp_framer_if #(
  parameter int DATA_W = 32
) ();
  logic              raw_valid;
  logic [DATA_W-1:0] raw_data;
  logic              adc_data_valid;
  logic [DATA_W-1:0] adc_data;
  logic              adc_data_sop;
  logic              adc_data_eop;

  // master is the framer: consumes raw samples, produces framed ones
  modport master (
    input  raw_valid, raw_data,
    output adc_data_valid, adc_data, adc_data_sop, adc_data_eop
  );

  modport slave (
    output raw_valid, raw_data,
    input  adc_data_valid, adc_data, adc_data_sop, adc_data_eop
  );
endinterface

// File: rtl/adc_chirp_framer.sv
// rtl/adc_chirp_framer.sv - gates the free-running ADC stream into framed chirps
// Optional FRAMER_TESTPAT_EN: replace sample data with {chirp_idx, sample_idx}.
module adc_chirp_framer #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int MAX_SMP = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_chirp_framer_if.master stream,
  input  logic             frame_start,
  input  logic             chirp_start,
  input  logic             sw_abort,
  input  logic [CNT_W-1:0] cfg_sample_num,
  input  logic [CNT_W-1:0] cfg_chirp_num,
  input  logic [CNT_W-1:0] cfg_skip_num,
  output logic [CNT_W-1:0] sample_num,
  output logic [CNT_W-1:0] chirp_num,
  output logic [CNT_W-1:0] chirp_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic             err_overlap,
  output logic             err_gap
);
  typedef enum logic [2:0] {IDLE, WAIT, SKIP, CAPTURE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] skip_num;
  logic [CNT_W-1:0] cnt;
  logic             idx_bump;
  logic             cfg_ok;
  logic             last_smp;

  assign cfg_ok = (cfg_sample_num != '0) &&
                  (cfg_sample_num <= CNT_W'(MAX_SMP)) &&
                  ((cfg_chirp_num == CNT_W'(32)) ||
                   (cfg_chirp_num == CNT_W'(64)) ||
                   (cfg_chirp_num == CNT_W'(128)));
  assign last_smp = (cnt == sample_num - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      skip_num              <= '0;
      cnt                   <= '0;
      idx_bump              <= 1'b0;
      sample_num            <= '0;
      chirp_num             <= '0;
      chirp_idx             <= '0;
      busy                  <= 1'b0;
      frame_done            <= 1'b0;
      cfg_err               <= 1'b0;
      err_overlap           <= 1'b0;
      err_gap               <= 1'b0;
      stream.adc_data_valid <= 1'b0;
      stream.adc_data       <= '0;
      stream.adc_data_sop   <= 1'b0;
      stream.adc_data_eop   <= 1'b0;
    end else begin
      stream.adc_data_valid <= 1'b0;
      stream.adc_data_sop   <= 1'b0;
      stream.adc_data_eop   <= 1'b0;
      frame_done            <= 1'b0;
      cfg_err               <= 1'b0;
      idx_bump              <= 1'b0;
      if (sw_abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              if (cfg_ok) begin
                sample_num  <= cfg_sample_num;
                chirp_num   <= cfg_chirp_num;
                skip_num    <= cfg_skip_num;
                chirp_idx   <= '0;
                cnt         <= '0;
                err_overlap <= 1'b0;
                err_gap     <= 1'b0;
                busy        <= 1'b1;
                state       <= WAIT;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          WAIT: begin
            // chirp_idx advances one cycle after eop so the eop beat still carries its own index
            if (idx_bump) chirp_idx <= chirp_idx + CNT_W'(1);
            if (chirp_start) begin
              cnt   <= '0;
              state <= (skip_num != '0) ? SKIP : CAPTURE;
            end
          end
          SKIP: begin
            if (chirp_start) err_overlap <= 1'b1;
            if (stream.raw_valid) begin
              if (cnt == skip_num - CNT_W'(1)) begin
                cnt   <= '0;
                state <= CAPTURE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          CAPTURE: begin
            if (chirp_start) err_overlap <= 1'b1;
            if (stream.raw_valid) begin
              stream.adc_data_valid <= 1'b1;
`ifdef FRAMER_TESTPAT_EN
              stream.adc_data <= DATA_W'({chirp_idx[15:0], cnt[15:0]});
`else
              stream.adc_data <= stream.raw_data;
`endif
              stream.adc_data_sop <= (cnt == '0);
              stream.adc_data_eop <= last_smp;
              if (last_smp) begin
                cnt <= '0;
                if (chirp_idx == chirp_num - CNT_W'(1)) begin
                  state <= DONE;
                end else begin
                  idx_bump <= 1'b1;
                  state    <= WAIT;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              err_gap <= 1'b1;
            end
          end
          DONE: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_chirp_framer.sv
// tb/tb_adc_chirp_framer.sv - scoreboard bench for adc_chirp_framer
module tb_adc_chirp_framer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        chirp_start = 1'b0;
  logic        sw_abort = 1'b0;
  logic [15:0] cfg_sample_num = '0;
  logic [15:0] cfg_chirp_num = '0;
  logic [15:0] cfg_skip_num = '0;
  logic [15:0] sample_num, chirp_num, chirp_idx;
  logic        busy, frame_done, cfg_err, err_overlap, err_gap;

  adc_chirp_framer_if #(.DATA_W(32)) bus ();

  adc_chirp_framer #(.DATA_W(32), .CNT_W(16), .MAX_SMP(4096)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stream         (bus),
    .frame_start    (frame_start),
    .chirp_start    (chirp_start),
    .sw_abort       (sw_abort),
    .cfg_sample_num (cfg_sample_num),
    .cfg_chirp_num  (cfg_chirp_num),
    .cfg_skip_num   (cfg_skip_num),
    .sample_num     (sample_num),
    .chirp_num      (chirp_num),
    .chirp_idx      (chirp_idx),
    .busy           (busy),
    .frame_done     (frame_done),
    .cfg_err        (cfg_err),
    .err_overlap    (err_overlap),
    .err_gap        (err_gap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [15:0] idx;
    int          cyc;
  } beat_t;

  beat_t       sb[$];
  beat_t       e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          done_exp = 0;
  logic [31:0] ramp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) n_done++;
      if (bus.adc_data_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(bus.adc_data), 64'hdead_beef_dead_beef);
        end else begin
          e = sb.pop_front();
          check("data", 64'(bus.adc_data), 64'(e.data));
          check("sop", 64'(bus.adc_data_sop), 64'(e.sop));
          check("eop", 64'(bus.adc_data_eop), 64'(e.eop));
          check("chirp_idx", 64'(chirp_idx), 64'(e.idx));
          check("latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic start_frame(input int sn, input int cn, input int sk);
    @(posedge clk); #1;
    cfg_sample_num = 16'(sn);
    cfg_chirp_num  = 16'(cn);
    cfg_skip_num   = 16'(sk);
    frame_start    = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic drive_chirp(input int idx, input int skip, input int n, input bit lead,
                             input bit cont, input int ovl_at, input int gap_at, input int abort_at);
    beat_t b;
    @(posedge clk); #1;
    chirp_start   = 1'b1;
    bus.raw_valid = lead;
    bus.raw_data  = ramp;
    if (lead) ramp++;
    for (int s = 0; s < skip; s++) begin
      @(posedge clk); #1;
      chirp_start   = 1'b0;
      bus.raw_valid = 1'b1;
      bus.raw_data  = ramp;
      ramp++;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chirp_start = 1'b0;
      if (i == gap_at) begin
        bus.raw_valid = 1'b0;
        @(posedge clk); #1;
      end
      chirp_start   = (i == ovl_at);
      bus.raw_valid = 1'b1;
      bus.raw_data  = ramp;
      if (i == abort_at) begin
        sw_abort = 1'b1;
        ramp++;
        break;
      end
`ifdef FRAMER_TESTPAT_EN
      b.data = {16'(idx), 16'(i)};
`else
      b.data = ramp;
`endif
      b.sop = (i == 0);
      b.eop = (i == n - 1);
      b.idx = 16'(idx);
      b.cyc = cyc + 1;
      sb.push_back(b);
      ramp++;
    end
    @(posedge clk); #1;
    chirp_start   = 1'b0;
    sw_abort      = 1'b0;
    bus.raw_valid = cont;
    bus.raw_data  = ramp;
    if (cont) ramp++;
  endtask

  task automatic finish_frame(input string tag, input int exp_idx);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_frame_done"}, 64'(n_done), 64'(done_exp));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_last_idx"}, 64'(chirp_idx), 64'(exp_idx));
    check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bus.raw_valid = 1'b0;
    bus.raw_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.adc_data_valid), 64'd0);
    check("rst_data", 64'(bus.adc_data), 64'd0);
    check("rst_sop_eop", 64'({bus.adc_data_sop, bus.adc_data_eop}), 64'd0);
    check("rst_cfg_out", 64'({sample_num, chirp_num, chirp_idx}), 64'd0);
    check("rst_flags", 64'({busy, frame_done, cfg_err, err_overlap, err_gap}), 64'd0);
    rst_n = 1'b1;

    // 8 samples x 32 chirps, skip 2, continuous raw_valid
    start_frame(8, 32, 2);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_cfg_latched", 64'({sample_num, chirp_num}), 64'({16'd8, 16'd32}));
    ramp = 32'd100;
    for (int c = 0; c < 32; c++) drive_chirp(c, 2, 8, 1'b1, 1'b1, -1, -1, -1);
    done_exp++;
    finish_frame("t1", 31);

    // ramp 0.. after chirp_start, skip 3, 4 samples: first chirp carries 3,4,5,6
    start_frame(4, 32, 3);
    for (int c = 0; c < 32; c++) begin
      ramp = 32'd0;
      drive_chirp(c, 3, 4, 1'b0, 1'b0, -1, -1, -1);
    end
    done_exp++;
    finish_frame("t2", 31);

    // overlapping chirp_start and a raw_valid gap inside CAPTURE
    start_frame(8, 32, 1);
    drive_chirp(0, 1, 8, 1'b1, 1'b1, 3, -1, -1);
    check("t3_overlap_set", 64'(err_overlap), 64'd1);
    drive_chirp(1, 1, 8, 1'b1, 1'b1, -1, 5, -1);
    check("t3_gap_set", 64'(err_gap), 64'd1);
    for (int c = 2; c < 32; c++) drive_chirp(c, 1, 8, 1'b1, 1'b1, -1, -1, -1);
    done_exp++;
    finish_frame("t3", 31);

    // illegal configurations are rejected
    start_frame(8, 48, 0);
    check("t4_cfg_err_chirp48", 64'(cfg_err), 64'd1);
    check("t4_busy_chirp48", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("t4_cfg_err_pulse", 64'(cfg_err), 64'd0);
    start_frame(0, 32, 0);
    check("t4_cfg_err_smp0", 64'(cfg_err), 64'd1);
    start_frame(4097, 64, 0);
    check("t4_cfg_err_smp_max", 64'(cfg_err), 64'd1);
    check("t4_busy_idle", 64'(busy), 64'd0);

    // abort at the 5th sample of chirp 3; legal frame_start clears sticky errors
    start_frame(8, 32, 2);
    check("t5_sticky_cleared", 64'({err_overlap, err_gap}), 64'd0);
    for (int c = 0; c < 3; c++) drive_chirp(c, 2, 8, 1'b1, 1'b0, -1, -1, -1);
    drive_chirp(3, 2, 8, 1'b1, 1'b0, -1, -1, 4);
    check("t5_abort_valid", 64'(bus.adc_data_valid), 64'd0);
    finish_frame("t5", 3);

    // next frame after abort: sample_num 1, no skip, 64 chirps
    start_frame(1, 64, 0);
    for (int c = 0; c < 64; c++) drive_chirp(c, 0, 1, 1'b1, 1'b1, -1, -1, -1);
    done_exp++;
    finish_frame("t6", 63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
